// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  localparam int unsigned NUM_PORTS    = 2;
  localparam int unsigned READ_LATENCY = 2;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick producing a one-hot grant.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  port_e                last_grant_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  // A lone requester wins; on a tie the port not granted last time wins.
  always_comb begin
    gnt_o = '0;
    if (req_i[0] && (!req_i[1] || last_grant_i == PORT1)) begin
      gnt_o[0] = 1'b1;
    end else if (req_i[1]) begin
      gnt_o[1] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a combinational-read memory.
// Grant cycle G, memory access in G+1, read response in G+2.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_we
);

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] gnt;
  logic                 any_gnt;
  port_e                win_port;
  logic                 win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  port_e                 last_grant_q, last_grant_d;
  logic                  issue_valid_q, issue_valid_d;
  port_e                 issue_port_q, issue_port_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [NUM_PORTS-1:0]  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  // Requests are masked during reset so no grant can escape while resetn is low.
  assign req = {m1_req, m0_req} & {NUM_PORTS{resetn}};

  rr_pick2 u_pick (
    .req_i       (req),
    .last_grant_i(last_grant_q),
    .gnt_o       (gnt)
  );

  assign m0_gnt  = gnt[0];
  assign m1_gnt  = gnt[1];
  assign any_gnt = |gnt;

  // Select the winning port's request fields.
  always_comb begin
    win_port  = PORT0;
    win_we    = m0_we;
    win_addr  = m0_addr;
    win_wdata = m0_wdata;
    if (gnt[1]) begin
      win_port  = PORT1;
      win_we    = m1_we;
      win_addr  = m1_addr;
      win_wdata = m1_wdata;
    end
  end

  // Issue-stage next state: load on grant, otherwise hold the bus and drop the strobe.
  always_comb begin
    last_grant_d  = last_grant_q;
    issue_valid_d = any_gnt;
    issue_port_d  = issue_port_q;
    mem_we_d      = any_gnt & win_we;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    if (any_gnt) begin
      last_grant_d = win_port;
      issue_port_d = win_port;
      mem_addr_d   = win_addr;
      mem_wdata_d  = win_wdata;
    end
  end

  // Response-stage next state: capture memory read data for the tagged port.
  always_comb begin
    rvalid_d    = '0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    if (issue_valid_q && !mem_we_q) begin
      if (issue_port_q == PORT0) begin
        rvalid_d[0] = 1'b1;
        rdata0_d    = mem_data_in;
      end else begin
        rvalid_d[1] = 1'b1;
        rdata1_d    = mem_data_in;
      end
    end
  end

  // Pipeline registers; reset discards any in-flight issue or response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q  <= PORT1;
      issue_valid_q <= 1'b0;
      issue_port_q  <= PORT0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rvalid_q      <= '0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      issue_valid_q <= issue_valid_d;
      issue_port_q  <= issue_port_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rvalid_q      <= rvalid_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
    end
  end

  assign mem_address  = mem_addr_q;
  assign mem_data_out = mem_wdata_q;
  assign mem_we       = mem_we_q;
  assign m0_rvalid    = rvalid_q[0];
  assign m1_rvalid    = rvalid_q[1];
  assign m0_rdata     = rdata0_q;
  assign m1_rdata     = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: attached memory, transaction-level model and directed tests.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_gnt, m0_rvalid;
  logic [DW-1:0] m0_rdata;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_gnt, m1_rvalid;
  logic [DW-1:0] m1_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_out, mem_data_in;
  logic          mem_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .mem_we(mem_we)
  );

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (32'h5A000000 ^ a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory instance: combinational read, write on the clock edge.
  logic [31:0] mem [0:1023];
  assign mem_data_in = mem[mem_address[11:2]];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = init_word(32'(i * 4));
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_address[11:2]] <= mem_data_out;
    end
  end

  // Reset pulses that fall between two checker samples still flush the model.
  bit rst_seen = 1'b0;
  initial forever begin
    @(negedge resetn);
    rst_seen = 1'b1;
  end

  // Transaction-level model: grants decided from the round-robin rule,
  // accesses scheduled one cycle after grant, read data one cycle later.
  typedef struct { bit we; bit port; logic [31:0] addr; logic [31:0] wdata; } iss_t;
  typedef struct { bit port; logic [31:0] data; } rsp_t;
  iss_t        iss_s[int];
  rsp_t        rsp_s[int];
  logic [31:0] shadow [0:1023];
  bit          m_last;
  logic [31:0] m_addr, m_wdata;
  int          cyc;

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = init_word(32'(i * 4));
    m_last = 1'b1; m_addr = '0; m_wdata = '0; cyc = 0;
    forever begin
      bit e0, e1, er0, er1;
      logic [31:0] ed0, ed1;
      iss_t it;
      @(negedge clk);
      if (!resetn || rst_seen) begin
        iss_s.delete(); rsp_s.delete();
        m_last = 1'b1; m_addr = '0; m_wdata = '0;
        rst_seen = 1'b0;
      end
      if (!resetn) begin
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_address, 0);
        chk("rst_mem_dout", mem_data_out, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
      end else begin
        e0 = m0_req && (!m1_req || m_last);
        e1 = m1_req && !e0;
        chk("m0_gnt", m0_gnt, e0);
        chk("m1_gnt", m1_gnt, e1);
        if (iss_s.exists(cyc)) begin
          it = iss_s[cyc];
          iss_s.delete(cyc);
          chk("mem_we", mem_we, it.we);
          chk("mem_addr", mem_address, it.addr);
          chk("mem_dout", mem_data_out, it.wdata);
          m_addr = it.addr; m_wdata = it.wdata;
          if (it.we) shadow[it.addr[11:2]] = it.wdata;
          else rsp_s[cyc + 1] = '{it.port, shadow[it.addr[11:2]]};
        end else begin
          chk("idle_mem_we", mem_we, 0);
          chk("idle_mem_addr", mem_address, m_addr);
          chk("idle_mem_dout", mem_data_out, m_wdata);
        end
        er0 = 1'b0; er1 = 1'b0; ed0 = '0; ed1 = '0;
        if (rsp_s.exists(cyc)) begin
          if (rsp_s[cyc].port) begin er1 = 1'b1; ed1 = rsp_s[cyc].data; end
          else begin er0 = 1'b1; ed0 = rsp_s[cyc].data; end
          rsp_s.delete(cyc);
        end
        chk("m0_rvalid", m0_rvalid, er0);
        chk("m1_rvalid", m1_rvalid, er1);
        if (er0) chk("m0_rdata", m0_rdata, ed0);
        if (er1) chk("m1_rdata", m1_rdata, ed1);
        if (e0) iss_s[cyc + 1] = '{m0_we, 1'b0, m0_addr, m0_wdata};
        if (e1) iss_s[cyc + 1] = '{m1_we, 1'b1, m1_addr, m1_wdata};
        if (e0 || e1) m_last = e1;
      end
      cyc++;
    end
  end

  // Sample grants mid-cycle, then advance to just after the next rising edge.
  task automatic next_cycle(output bit g0, output bit g1);
    @(negedge clk);
    #1;
    g0 = m0_gnt;
    g1 = m1_gnt;
    @(posedge clk);
    #1;
  endtask

  // Present a request on one port and hold it until granted (bounded).
  task automatic req(input bit p, input bit we, input logic [31:0] a,
                     input logic [31:0] d, output int waited);
    bit g0, g1;
    if (p) begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; end
    else begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; end
    waited = 0;
    for (int i = 0; i < 10; i++) begin
      next_cycle(g0, g1);
      waited++;
      if ((p && g1) || (!p && g0)) return;
    end
    checks++;
    errors++;
    $display("FAIL req_timeout: port %0d got no grant, required within 10 cycles", p);
  endtask

  initial begin
    bit g0, g1;
    int w;
    logic [31:0] a0, a1;

    // Reset with m0 requesting: nothing may be granted until release.
    m0_req = 1'b1; m0_addr = 32'h100;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_hold_gnt", m0_gnt, 0);
    chk("rst_hold_we", mem_we, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // m0 read 0x100: grant in the first cycle after reset.
    req(1'b0, 1'b0, 32'h100, 32'h0, w);
    m0_req = 1'b0;
    chk("first_gnt_wait", w, 1);
    chk("rd_issue_addr", mem_address, 32'h100);
    chk("rd_issue_we", mem_we, 0);
    next_cycle(g0, g1);
    chk("rd_rvalid", m0_rvalid, 1);
    chk("rd_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_quiet", m1_rvalid, 0);

    // m1 write 0x804, then read it back from both ports.
    req(1'b1, 1'b1, 32'h804, 32'h12345678, w);
    m1_req = 1'b0;
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_address, 32'h804);
    chk("wr_dout", mem_data_out, 32'h12345678);
    next_cycle(g0, g1);
    chk("wr_we_drop", mem_we, 0);
    chk("wr_no_rvalid", m1_rvalid, 0);
    req(1'b0, 1'b0, 32'h804, 32'h0, w);
    m0_req = 1'b0;
    next_cycle(g0, g1);
    chk("rb_rdata", m0_rdata, 32'h12345678);
    req(1'b1, 1'b0, 32'h804, 32'h0, w);
    m1_req = 1'b0;
    next_cycle(g0, g1);
    chk("rb1_rdata", m1_rdata, 32'h12345678);

    // Both ports stream reads; last grant was m1, so m0 leads and they alternate.
    a0 = 32'h0; a1 = 32'h400;
    m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = a0; m1_addr = a1;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      next_cycle(g0, g1);
      chk("alt_g0", g0, (i % 2 == 0));
      chk("alt_g1", g1, (i % 2 == 1));
      if (g0) a0 += 4;
      if (g1) a1 += 4;
      m0_addr = a0; m1_addr = a1;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) next_cycle(g0, g1);

    // Write in flight when reset asserts: strobe drops at once, no write lands.
    req(1'b1, 1'b1, 32'h300, 32'hCAFEF00D, w);
    m1_req = 1'b0;
    chk("rstw_we_before", mem_we, 1);
    resetn = 1'b0;
    #1;
    chk("rstw_we_async", mem_we, 0);
    chk("rstw_addr_async", mem_address, 0);
    repeat (2) next_cycle(g0, g1);
    resetn = 1'b1;

    // Read in flight, brief reset pulse in G+1: no rvalid in G+2.
    req(1'b0, 1'b0, 32'h200, 32'h0, w);
    m0_req = 1'b0;
    resetn = 1'b0;
    #1;
    chk("rstr_addr_async", mem_address, 0);
    #1;
    resetn = 1'b1;
    next_cycle(g0, g1);
    chk("rstr_no_rvalid", m0_rvalid, 0);

    // Accepts requests after reset; the aborted write never reached memory.
    req(1'b0, 1'b0, 32'h300, 32'h0, w);
    m0_req = 1'b0;
    chk("post_rst_wait", w, 1);
    next_cycle(g0, g1);
    chk("post_rst_rdata", m0_rdata, 32'h5A000300);

    // Back-to-back write then read of 0xFFC: data visible at G+3.
    req(1'b0, 1'b1, 32'hFFC, 32'h5, w);
    req(1'b0, 1'b0, 32'hFFC, 32'h0, w);
    m0_req = 1'b0;
    chk("b2b_wait", w, 1);
    next_cycle(g0, g1);
    chk("b2b_rvalid", m0_rvalid, 1);
    chk("b2b_rdata", m0_rdata, 32'h5);

    repeat (3) next_cycle(g0, g1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
